rx_frame_fifo: RTL and testbench
================================

# rx_frame_fifo

Frame-aware receive buffer sitting directly downstream of the Rx chain's depacketizer byte stream (`data_tdata`/`data_tvalid`/`data_tlast`/`data_tuser`). It stores each incoming frame speculatively and commits it only when the frame ends cleanly. Frames that are flagged bad or that overflow the buffer are rolled back. Committed frames are replayed on an AXI-Stream master port with backpressure, for the host-side DMA/UART bridge.

## Interface
- `ADDR_W`, 8: log2 of buffer depth; DEPTH = 2^ADDR_W bytes.
- `CNT_W`, 16: width of the frame statistics counters.
- `clk_32M768`  in  1  system clock; all logic is on its rising edge.
- `rst_32M768`  in  1  asynchronous, active-high reset.
- `s_tdata`  in  8  received byte.
- `s_tvalid`  in  1  single-cycle strobe; at most one byte per cycle. There is no ready signal: the source cannot stall.
- `s_tlast`  in  1  last byte of frame; qualified by `s_tvalid`.
- `s_tuser`  in  1  frame-bad flag; sampled only on the `s_tlast` beat.
- `m_tdata`  out  8  output byte.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  downstream ready.
- `m_tlast`  out  1  last byte of a committed frame.
- `level`  out  ADDR_W+1  bytes held, committed plus speculative (`wr_ptr - rd_ptr`).
- `frames_ok`  out  CNT_W  committed-frame count, saturating.
- `frames_drop`  out  CNT_W  dropped-frame count, saturating.
- `overflow`  out  1  one-cycle pulse on the first byte lost to a full buffer.

## Operation
- **Storage:** a simple dual-port RAM of DEPTH × 9 bits, each word `{tlast, tdata}`, with a synchronous read.
- **Pointers:** three pointers, each ADDR_W+1 bits wide and wrapping modulo 2^(ADDR_W+1):
  - `wr_ptr`: speculative write pointer.
  - `cm_ptr`: commit pointer.
  - `rd_ptr`: read pointer.
- **Full condition:** `wr_ptr - rd_ptr == DEPTH`.
- **Write FSM states:**
  - RECV: accept bytes.
  - DROP: discard bytes until end of frame.
- **RECV, `s_tvalid` while not full:**
  - Write `{s_tlast, s_tdata}` at `wr_ptr` and increment `wr_ptr`.
  - If `s_tlast && !s_tuser`: set `cm_ptr <= wr_ptr + 1` and increment `frames_ok`.
  - If `s_tlast && s_tuser`: set `wr_ptr <= cm_ptr` (rollback) and increment `frames_drop`.
- **RECV, `s_tvalid` while full:**
  - Do not write; pulse `overflow`.
  - Set `wr_ptr <= cm_ptr`.
  - If `s_tlast`: increment `frames_drop` and stay in RECV. Otherwise go to DROP.
- **DROP:**
  - Ignore all bytes.
  - On `s_tvalid && s_tlast`: increment `frames_drop` and go to RECV.
- **Frame size limit:** a frame longer than DEPTH − (committed bytes) always overflows and is dropped. A frame of exactly the free space commits.
- **Read side:**
  - A read issues when `rd_ptr != cm_ptr`, no read is in flight, and (`!m_tvalid` or `m_tready`).
  - RAM data loads `m_tdata`/`m_tlast` and sets `m_tvalid` on the following edge.
  - A handshake (`m_tvalid && m_tready`) with no new data arriving clears `m_tvalid`.
  - `m_tvalid` never asserts for uncommitted bytes.
- **Output stability:** `m_tdata`/`m_tlast` hold while `m_tvalid && !m_tready`.
- **Counters:** saturate at 2^CNT_W − 1 and do not wrap.

## Timing
- **Reset values:**
  - All pointers = 0; FSM = RECV.
  - `m_tvalid`, `m_tlast`, `m_tdata` = 0.
  - `level` = 0; `frames_ok` and `frames_drop` = 0; `overflow` = 0.
  - Reset is asynchronous, so outputs clear without waiting for a clock edge.
- **Reset mid-frame or mid-read:** the partial frame and all buffered data are lost. The first `s_tvalid` after release starts a new frame.
- **Commit to output latency:** the `s_tlast` beat updates `cm_ptr` at edge N. The read issues in cycle N+1, and `m_tvalid` = 1 after edge N+2.
- **Output throughput:** at most one byte per 2 cycles. This is sufficient because input is ≤ 1 byte per 16 cycles.
- **Simultaneous write and read:** both are legal in the same cycle. `level` reflects both updates at the next edge.
- **Rollback coinciding with read:** `rd_ptr` is unaffected, since reads never pass `cm_ptr`.
- **`overflow` pulse:** asserted in the cycle after the offending `s_tvalid`.
- **Counters:** update one edge after the `s_tlast` beat.

## Test plan
- **Good frame:** reset, then send a 4-byte frame 0x11, 0x22, 0x33, 0x44 (tlast on 0x44, tuser = 0) with `m_tready` = 1.
  - Output is exactly those bytes, `m_tlast` only on 0x44.
  - First `m_tvalid` 2 cycles after the tlast beat.
  - `frames_ok` = 1.
- **Bad frame between good frames:** send a 3-byte frame with tuser = 1 on tlast, surrounded by good frames A and B.
  - Output is A then B only.
  - `frames_drop` = 1.
  - `level` returns to the pre-frame value one cycle after the bad tlast.
- **Overflow:** with ADDR_W = 4 and `m_tready` = 0, send a committed 10-byte frame followed by a 10-byte frame.
  - `overflow` pulses once, on the 7th byte of frame 2.
  - FSM enters DROP; `frames_drop` = 1.
  - After raising `m_tready`, only the 10 bytes of frame 1 appear.
- **Backpressure:** toggle `m_tready` pseudo-randomly during a 20-byte frame.
  - No byte lost or duplicated.
  - `m_tdata` stable while stalled.
  - `level` = 0 at the end.
- **Pointer wrap:** with ADDR_W = 4, stream 100 good 5-byte frames with `m_tready` = 1.
  - All 500 bytes appear in order.
  - `frames_ok` = 100.
- **Reset mid-operation:** assert `rst_32M768` asynchronously mid-frame while `m_tvalid` = 1.
  - `m_tvalid` drops before the next clock edge.
  - After release, a new 2-byte good frame is output correctly.

Source files
------------

// File: rtl/rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_fifo
// Description : Frame-aware receive buffer. Incoming bytes are written
//               speculatively and committed only when a frame ends cleanly.
//               Bad or overflowing frames are rolled back. Committed bytes
//               are replayed on an AXI-Stream master port with backpressure.
// Ports       : clk_32M768 / rst_32M768  - clock, async active-high reset
//               s_tdata/tvalid/tlast/tuser - byte stream in (no ready)
//               m_tdata/tvalid/tlast/tready - AXI-Stream out
//               level       - bytes held (committed + speculative)
//               frames_ok   - committed-frame count (saturating)
//               frames_drop - dropped-frame count (saturating)
//               overflow    - pulse on first byte lost to a full buffer
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_fifo #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_32M768,
    input  logic              rst_32M768,
    input  logic [7:0]        s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    input  logic              s_tuser,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  frames_ok,
    output logic [CNT_W-1:0]  frames_drop,
    output logic              overflow
);

    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_RECV = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;

    logic [ADDR_W:0] wr_ptr;   // speculative write pointer
    logic [ADDR_W:0] cm_ptr;   // end of committed data
    logic [ADDR_W:0] fe_ptr;   // next committed word to fetch from RAM
    logic [ADDR_W:0] rd_ptr;   // oldest byte not yet handed off downstream

    logic [8:0]      mem [DEPTH];
    logic [8:0]      rd_word;
    logic            inflight;

    logic            full;
    logic            accept;
    logic            lost;
    logic            commit;
    logic            rollback;
    logic            drop_frame;
    logic            rd_issue;
    logic            handshake;

    // rd_ptr only advances on the downstream handshake, so the byte sitting in
    // the output register still counts as held. This keeps its RAM slot
    // reserved and makes level include it.
    assign full      = (wr_ptr - rd_ptr) == FULL_LVL;
    assign level     = wr_ptr - rd_ptr;
    assign handshake = m_tvalid && m_tready;

    // A fetch may only start when the output register will be free by the
    // time the RAM data arrives on the following edge.
    assign rd_issue  = (fe_ptr != cm_ptr) && !inflight && (!m_tvalid || m_tready);

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            state <= ST_RECV;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RECV: if (s_tvalid && full && !s_tlast) state_nxt = ST_DROP;
            ST_DROP: if (s_tvalid && s_tlast)          state_nxt = ST_RECV;
            default:                                   state_nxt = ST_RECV;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        accept     = 1'b0;
        lost       = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        drop_frame = 1'b0;
        case (state)
            ST_RECV: begin
                accept     = s_tvalid && !full;
                lost       = s_tvalid && full;
                commit     = accept && s_tlast && !s_tuser;
                rollback   = (accept && s_tlast && s_tuser) || lost;
                drop_frame = (accept && s_tlast && s_tuser) || (lost && s_tlast);
            end
            ST_DROP: begin
                drop_frame = s_tvalid && s_tlast;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- storage
    always_ff @(posedge clk_32M768) begin
        if (accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_tlast, s_tdata};
        end
        if (rd_issue) begin
            rd_word <= mem[fe_ptr[ADDR_W-1:0]];
        end
    end

    // ---------------------------------------------------------------- write side
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            frames_ok   <= '0;
            frames_drop <= '0;
            overflow    <= 1'b0;
        end else begin
            if (rollback) begin
                wr_ptr <= cm_ptr;
            end else if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit) begin
                cm_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit && frames_ok != CNT_MAX) begin
                frames_ok <= frames_ok + CNT_ONE;
            end
            if (drop_frame && frames_drop != CNT_MAX) begin
                frames_drop <= frames_drop + CNT_ONE;
            end
            overflow <= lost;
        end
    end

    // ---------------------------------------------------------------- read side
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            fe_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= 8'h00;
            m_tlast  <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (rd_issue) begin
                fe_ptr <= fe_ptr + PTR_ONE;
            end
            if (handshake) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A load never coincides with a pending stalled byte: the fetch
            // was only issued when the output register would be empty.
            if (inflight) begin
                m_tvalid <= 1'b1;
                m_tlast  <= rd_word[8];
                m_tdata  <= rd_word[7:0];
            end else if (handshake) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_fifo
// Description : Self-checking bench for rx_frame_fifo. Instance "a" uses an
//               8-bit address (256 bytes), instance "b" a 4-bit address
//               (16 bytes) for overflow and pointer-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tuser;
    logic        sel;           // 0 drives instance a, 1 drives instance b
    logic        tv_a;
    logic        tv_b;

    logic [7:0]  a_tdata;
    logic        a_tvalid;
    logic        a_tlast;
    logic        a_ready;
    logic [8:0]  a_level;
    logic [15:0] a_ok;
    logic [15:0] a_drop;
    logic        a_ovf;

    logic [7:0]  b_tdata;
    logic        b_tvalid;
    logic        b_tlast;
    logic        b_ready;
    logic [4:0]  b_level;
    logic [15:0] b_ok;
    logic [15:0] b_drop;
    logic        b_ovf;

    assign tv_a = s_tvalid & ~sel;
    assign tv_b = s_tvalid & sel;

    always #5 clk = ~clk;

    rx_frame_fifo #(.ADDR_W(8), .CNT_W(16)) ua (
        .clk_32M768 (clk),      .rst_32M768 (rst),
        .s_tdata    (s_tdata),  .s_tvalid   (tv_a),
        .s_tlast    (s_tlast),  .s_tuser    (s_tuser),
        .m_tdata    (a_tdata),  .m_tvalid   (a_tvalid),
        .m_tready   (a_ready),  .m_tlast    (a_tlast),
        .level      (a_level),  .frames_ok  (a_ok),
        .frames_drop(a_drop),   .overflow   (a_ovf)
    );

    rx_frame_fifo #(.ADDR_W(4), .CNT_W(16)) ub (
        .clk_32M768 (clk),      .rst_32M768 (rst),
        .s_tdata    (s_tdata),  .s_tvalid   (tv_b),
        .s_tlast    (s_tlast),  .s_tuser    (s_tuser),
        .m_tdata    (b_tdata),  .m_tvalid   (b_tvalid),
        .m_tready   (b_ready),  .m_tlast    (b_tlast),
        .level      (b_level),  .frames_ok  (b_ok),
        .frames_drop(b_drop),   .overflow   (b_ovf)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic which, input logic [7:0] d, input logic l,
                        input logic u, input int gap);
        sel      = which;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        repeat (gap) tick();
    endtask

    // ------------------------------------------------------------ output monitors
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic       a_stall_prev = 1'b0;
    logic [8:0] a_prev       = '0;
    int         stab_err     = 0;

    always @(negedge clk) begin
        if (a_tvalid && a_ready) qa.push_back({a_tlast, a_tdata});
        if (b_tvalid && b_ready) qb.push_back({b_tlast, b_tdata});
        if (!rst && a_stall_prev && !(a_tvalid && {a_tlast, a_tdata} == a_prev))
            stab_err <= stab_err + 1;
        a_stall_prev <= a_tvalid && !a_ready;
        a_prev       <= {a_tlast, a_tdata};
    end

    // ------------------------------------------------------------ good-frame table
    typedef struct {
        logic       tv;
        logic [7:0] d;
        logic       tl;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        int         elvl;
        int         eok;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int         mism;
        logic [7:0] bv;

        rst      = 1'b1;
        sel      = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset values, before any clock edge.
        #2;
        chk("rst_a_tvalid", a_tvalid, 0);
        chk("rst_a_tdata",  a_tdata,  0);
        chk("rst_a_tlast",  a_tlast,  0);
        chk("rst_a_level",  a_level,  0);
        chk("rst_a_ok",     a_ok,     0);
        chk("rst_a_drop",   a_drop,   0);
        chk("rst_a_ovf",    a_ovf,    0);
        chk("rst_b_level",  b_level,  0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // tv, d, tl, rdy | ev, ed, el, level, frames_ok
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1, 0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2, 0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3, 0};
        tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4, 1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4, 1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 4, 1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3, 1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 3, 1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 2, 1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1, 1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1};

        sel = 1'b0;
        for (int i = 0; i < 13; i++) begin
            s_tvalid = tbl[i].tv;
            s_tdata  = tbl[i].d;
            s_tlast  = tbl[i].tl;
            s_tuser  = 1'b0;
            a_ready  = tbl[i].rdy;
            tick();
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            chk($sformatf("good_tvalid[%0d]", i), a_tvalid, tbl[i].ev);
            chk($sformatf("good_level[%0d]", i),  a_level,  tbl[i].elvl);
            chk($sformatf("good_ok[%0d]", i),     a_ok,     tbl[i].eok);
            if (tbl[i].ev) begin
                chk($sformatf("good_tdata[%0d]", i), a_tdata, tbl[i].ed);
                chk($sformatf("good_tlast[%0d]", i), a_tlast, tbl[i].el);
            end
        end

        // ------------------------------------------------ bad frame between good frames
        qa.delete();
        a_ready = 1'b1;
        send(0, 8'hA1, 0, 0, 3);
        send(0, 8'hA2, 0, 0, 3);
        send(0, 8'hA3, 1, 0, 3);
        repeat (12) tick();
        chk("bad_lvl_pre", a_level, 0);
        send(0, 8'hB1, 0, 0, 3);
        send(0, 8'hB2, 0, 0, 0);
        chk("bad_lvl_mid", a_level, 2);
        repeat (3) tick();
        send(0, 8'hB3, 1, 1, 0);
        chk("bad_lvl_after", a_level, 0);
        chk("bad_drop", a_drop, 1);
        send(0, 8'hC1, 0, 0, 3);
        send(0, 8'hC2, 1, 0, 3);
        repeat (12) tick();
        chk("bad_qsize", qa.size(), 5);
        if (qa.size() == 5) begin
            chk("bad_q0", qa[0], {1'b0, 8'hA1});
            chk("bad_q1", qa[1], {1'b0, 8'hA2});
            chk("bad_q2", qa[2], {1'b1, 8'hA3});
            chk("bad_q3", qa[3], {1'b0, 8'hC1});
            chk("bad_q4", qa[4], {1'b1, 8'hC2});
        end
        chk("bad_ok", a_ok, 3);

        // ------------------------------------------------ backpressure
        qa.delete();
        a_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(0, 8'h40 + 8'(i), (i == 19), 0, 1);
        for (int i = 0; i < 150; i++) begin
            a_ready = 1'($urandom_range(0, 1));
            tick();
        end
        a_ready = 1'b1;
        repeat (20) tick();
        chk("bp_qsize", qa.size(), 20);
        mism = 0;
        if (qa.size() == 20) begin
            for (int i = 0; i < 20; i++)
                if (qa[i] !== {(i == 19), 8'h40 + 8'(i)}) mism++;
        end
        chk("bp_data", mism, 0);
        chk("bp_stable", stab_err, 0);
        chk("bp_level", a_level, 0);

        // ------------------------------------------------ overflow (16-byte buffer)
        qb.delete();
        b_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(1, 8'h60 + 8'(i), (i == 9), 0, 2);
        repeat (4) tick();
        chk("ovf_lvl1", b_level, 10);
        chk("ovf_ok1", b_ok, 1);
        for (int i = 0; i < 10; i++) begin
            send(1, 8'h70 + 8'(i), (i == 9), 0, 0);
            chk($sformatf("ovf_pulse[%0d]", i), b_ovf, (i == 6));
            if (i == 5) chk("ovf_lvl_full", b_level, 16);
            if (i == 8) chk("ovf_drop_mid", b_drop, 0);
            repeat (2) tick();
        end
        chk("ovf_drop", b_drop, 1);
        chk("ovf_lvl2", b_level, 10);
        b_ready = 1'b1;
        repeat (30) tick();
        chk("ovf_qsize", qb.size(), 10);
        mism = 0;
        if (qb.size() == 10) begin
            for (int i = 0; i < 10; i++)
                if (qb[i] !== {(i == 9), 8'h60 + 8'(i)}) mism++;
        end
        chk("ovf_data", mism, 0);
        chk("ovf_ok2", b_ok, 1);

        // ------------------------------------------------ pointer wrap
        qb.delete();
        b_ready = 1'b1;
        for (int f = 0; f < 100; f++)
            for (int i = 0; i < 5; i++) begin
                bv = 8'(f * 5 + i);
                send(1, bv, (i == 4), 0, 2);
            end
        repeat (20) tick();
        chk("wrap_qsize", qb.size(), 500);
        mism = 0;
        if (qb.size() == 500) begin
            for (int k = 0; k < 500; k++) begin
                bv = 8'(k);
                if (qb[k] !== {((k % 5) == 4), bv}) mism++;
            end
        end
        chk("wrap_data", mism, 0);
        chk("wrap_ok", b_ok, 101);
        chk("wrap_level", b_level, 0);

        // ------------------------------------------------ asynchronous reset mid-operation
        a_ready = 1'b0;
        send(0, 8'hC1, 0, 0, 1);
        send(0, 8'hC2, 1, 0, 1);
        for (int i = 0; i < 10 && !a_tvalid; i++) tick();
        chk("rst_pre_valid", a_tvalid, 1);
        send(0, 8'hD1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_tvalid", a_tvalid, 0);
        chk("rst_async_tdata",  a_tdata,  0);
        chk("rst_async_level",  a_level,  0);
        chk("rst_async_ok",     a_ok,     0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        qa.delete();
        a_ready = 1'b1;
        send(0, 8'hE1, 0, 0, 2);
        send(0, 8'hE2, 1, 0, 2);
        repeat (10) tick();
        chk("rst_post_qsize", qa.size(), 2);
        if (qa.size() == 2) begin
            chk("rst_post_q0", qa[0], {1'b0, 8'hE1});
            chk("rst_post_q1", qa[1], {1'b1, 8'hE2});
        end
        chk("rst_post_ok", a_ok, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
